// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code set 2 key decoder.
//   - byte constants for the prefixes and the special (non-key) bytes
//   - decoder state encoding
//   - 10-bit key event {extended, released, code}
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] PS2_OVR0  = 8'h00;
  localparam logic [7:0] PS2_OVR1  = 8'hFF;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_RSND  = 8'hFE;
  localparam logic [7:0] PS2_BATF  = 8'hFC;

  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CTRL   = 8'h14;
  localparam logic [7:0] PS2_ALT    = 8'h11;

  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam logic [2:0] PS2_PAUSE_LEN  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } dec_state_t;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } key_event_t;

  function automatic logic is_special(input logic [7:0] b);
    return (b == PS2_OVR0) || (b == PS2_OVR1) || (b == PS2_BAT) ||
           (b == PS2_ECHO) || (b == PS2_ACK)  || (b == PS2_RSND) ||
           (b == PS2_BATF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead key event FIFO.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and event
//   pop           : read request (ignored when empty)
//   head          : event at the head, valid while !empty
//   empty, full   : registered status flags
//   drop          : push refused because full with no simultaneous pop
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  key_event_t din,
  input  logic       pop,
  output key_event_t head,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  key_event_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot on the same edge, so push-while-full is accepted
  // when accompanied by a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder.
//   clk, rst            : clock, asynchronous active-high reset
//   data_req            : byte request to the receiver (held high after reset)
//   data, data_err,
//   data_ack            : byte from the receiver, accepted when data_ack&&data_req
//   key_valid/ready     : show-ahead event FIFO handshake
//   key_code/extended/
//   key_released        : head event
//   mod_shift/ctrl/alt  : live modifier state
//   overflow, overflow_clr : sticky dropped-event flag and its clear
//   err_count           : saturating count of parity-error bytes
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 data_req,
  input  logic [7:0]           data,
  input  logic                 data_err,
  input  logic                 data_ack,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [7:0]           key_code,
  output logic                 key_extended,
  output logic                 key_released,
  output logic                 mod_shift,
  output logic                 mod_ctrl,
  output logic                 mod_alt,
  output logic                 overflow,
  input  logic                 overflow_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  dec_state_t state;
  logic [2:0] skip_cnt;
  logic       accept;
  logic       ev_push;
  key_event_t ev;
  key_event_t head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_drop;
  logic       lshift, rshift, lctrl, rctrl, lalt, ralt;
  logic       in_ext, in_brk;

  assign accept = data_ack && data_req;
  assign in_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign in_brk = (state == ST_BRK) || (state == ST_EXT_BRK);

  // Event generation is combinational so the FIFO write lands on the
  // same edge that accepts the completing byte.
  always_comb begin
    ev_push = 1'b0;
    ev      = '0;
    if (accept && !data_err) begin
      if (state == ST_PAUSE) begin
        if (skip_cnt == 3'd1) begin
          ev_push = 1'b1;
          ev      = '{extended: 1'b1, released: 1'b0, code: PS2_PAUSE_CODE};
        end
      end else if (!is_special(data) && data != PS2_EXT &&
                   data != PS2_BRK && data != PS2_PAUSE) begin
        ev_push = 1'b1;
        ev      = '{extended: in_ext, released: in_brk, code: data};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_req  <= 1'b0;
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      lalt      <= 1'b0;
      ralt      <= 1'b0;
    end else begin
      data_req <= 1'b1;

      if (accept) begin
        if (data_err) begin
          state    <= ST_IDLE;
          skip_cnt <= '0;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end else if (state == ST_PAUSE) begin
          skip_cnt <= skip_cnt - 1'b1;
          if (skip_cnt == 3'd1) state <= ST_IDLE;
        end else if (is_special(data)) begin
          state <= ST_IDLE;
        end else if (data == PS2_EXT) begin
          state <= ST_EXT;
        end else if (data == PS2_BRK) begin
          if (state == ST_IDLE)     state <= ST_BRK;
          else if (state == ST_EXT) state <= ST_EXT_BRK;
        end else if (data == PS2_PAUSE) begin
          state    <= ST_PAUSE;
          skip_cnt <= PS2_PAUSE_LEN;
        end else begin
          state <= ST_IDLE;
        end
      end

      // E0 12 / E0 59 are fake shifts and deliberately leave shift alone.
      if (ev_push) begin
        if (!ev.extended && ev.code == PS2_LSHIFT) lshift <= !ev.released;
        if (!ev.extended && ev.code == PS2_RSHIFT) rshift <= !ev.released;
        if (ev.code == PS2_CTRL) begin
          if (ev.extended) rctrl <= !ev.released;
          else             lctrl <= !ev.released;
        end
        if (ev.code == PS2_ALT) begin
          if (ev.extended) ralt <= !ev.released;
          else             lalt <= !ev.released;
        end
      end

      if (fifo_drop)         overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (ev_push),
    .din  (ev),
    .pop  (key_ready),
    .head (head),
    .empty(fifo_empty),
    .full (fifo_full),
    .drop (fifo_drop)
  );

  assign key_valid    = !fifo_empty;
  assign key_code     = fifo_empty ? '0 : head.code;
  assign key_extended = !fifo_empty && head.extended;
  assign key_released = !fifo_empty && head.released;
  assign mod_shift    = lshift || rshift;
  assign mod_ctrl     = lctrl || rctrl;
  assign mod_alt      = lalt || ralt;

endmodule
